// File: rtl/sub3_datapath_seq.sv
// sub3_datapath_seq: computes y = a - b - c in two cycles on one shared adder.
// It also returns a borrow flag and uses a start/busy/done handshake.
module sub3_datapath_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             borrow
);
    typedef enum logic [1:0] {IDLE, SUB1, SUB2} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] aq, bq, cq, acc, op_a, op_b, sum;
    logic b1, cout;
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (start ? SUB1 : IDLE) : state == SUB1 ? SUB2 : IDLE;
    end
    // The shared adder performs a subtraction as a + ~x + 1. A carry-out of 0 means a borrow occurred.
    assign op_a = state == SUB2 ? acc : aq;
    assign op_b = state == SUB2 ? ~cq : ~bq;
    assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(1);
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            aq     <= '0;
            bq     <= '0;
            cq     <= '0;
            acc    <= '0;
            b1     <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= state == SUB2;
            if (state == IDLE && start) begin
                aq <= a;
                bq <= b;
                cq <= c;
            end
            if (state == SUB1) begin
                acc <= sum;
                b1  <= ~cout;
            end
            if (state == SUB2) begin
                y      <= sum;
                borrow <= b1 | ~cout;
            end
        end
    end
endmodule

// File: doc/sub3_datapath_seq.md
# sub3_datapath_seq

Sequential three-operand subtractor: computes y = a − b − c with a single shared WIDTH-bit adder over two cycles, plus a borrow flag. It is the subtract-direction counterpart to the team's three-operand adder datapath and demonstrates resource sharing: one adder, a small FSM, and a start/done handshake instead of a chain of adders.

## Interface
- WIDTH, 16, operand and result width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepted start edge
- b  input  WIDTH  first subtrahend, captured on the accepted start edge
- c  input  WIDTH  second subtrahend, captured on the accepted start edge
- busy  output  1  high while an operation is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse; y and borrow are valid from this cycle
- y  output  WIDTH  (a − b − c) mod 2^WIDTH, held until the next done
- borrow  output  1  high when the unsigned value a < b + c, held with y

## Operation
- States are IDLE, SUB1 and SUB2.
- **IDLE:** at a clock edge with start=1:
  - capture a, b and c into aq, bq and cq;
  - go to SUB1.
  - start=0 keeps the block in IDLE.
- **SUB1:** one shared adder computes aq + ~bq + 1 (carry-in 1).
  - acc ← sum.
  - b1 ← ~carry_out, i.e. aq < bq.
  - Go to SUB2.
- **SUB2:** the same adder computes acc + ~cq + 1.
  - y ← sum.
  - borrow ← b1 | ~carry_out.
  - done ← 1.
  - Go to IDLE.
- done is a registered pulse: it is cleared at every edge where the state is not SUB2.
- There is exactly one WIDTH-bit adder. Its operand-B mux selects ~bq or ~cq and its operand-A mux selects aq or acc.
- Arithmetic is unsigned, and y wraps modulo 2^WIDTH.
  - borrow=1 iff one or more wrap-arounds occurred, which equals (a < b + c) evaluated at WIDTH+2 bits.
- start while busy is ignored. It is not queued, and aq, bq and cq do not change.
- Inputs a, b and c may change freely after the accepting edge without affecting the result.
- y and borrow update only at the SUB2 edge. Between operations they hold the last result.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state goes to IDLE;
  - busy=0, done=0, y=0, borrow=0;
  - aq, bq, cq, acc and b1 are cleared to 0.
- On release, the first possible accepting edge is the first rising clk edge with rst_n=1.
- Reset asserted mid-operation aborts the operation: no done pulse, and y and borrow read 0.
- Latency: start is accepted at edge k.
  - busy=1 after edge k.
  - done=1 and y/borrow are valid after edge k+2.
  - busy=0 after edge k+2.
- Throughput: one operation per 3 cycles.
  - start held high continuously is accepted at edges k, k+3, k+6, …
  - done rises after k+2, k+5, …
- In the cycle where done=1 the state is IDLE, so start=1 in that cycle is accepted at the next edge.
- busy and done are never both 1.

## Test plan
- Reset, then apply a=100, b=30, c=20 with start for 1 cycle.
  - Required: busy=1 for 2 cycles, then done=1 for exactly 1 cycle.
  - Required: y=50, borrow=0.
- Apply a=10, b=20, c=5.
  - Required: y=0xFFF1, borrow=1.
- Apply a=0xFFFF, b=0xFFFF, c=0xFFFF.
  - Required: y=0x0001, borrow=1.
- Boundary cases:
  - a=5, b=5, c=0 gives y=0, borrow=0.
  - a=0x0000, b=0, c=1 gives y=0xFFFF, borrow=1.
- Accept a=100, b=30, c=20. One cycle later, pulse start with a=1, b=2, c=3 and change a.
  - Required: ignored; result y=50.
  - Required: only one done.
- Hold start=1 with a fixed stream (7,1,1) then (3,1,1) presented at each accept.
  - Required: done after edges k+2 and k+5, with y=5 then y=1.
- Assert rst_n=0 during SUB1.
  - Required: immediately busy=0, done=0, y=0, borrow=0.
  - Required: no done pulse afterwards.
  - Required: a new start after release completes normally.
